sha1_msg_padder: RTL and testbench
==================================

Name: sha1_msg_padder

Overview:
- Upstream feeder for the SHA-1 compression core.
- Accepts the raw message as a stream of 32-bit big-endian words, one per handshake.
- Applies FIPS 180-4 padding: 0x80 byte, zero fill, 64-bit bit-length.
- Emits complete 512-bit blocks with a valid/ready handshake, plus first/last flags so the core knows when to load the IV and when to publish the digest.

Parameters:
- MAX_LEN_BITS, 64, width of internal bit-length counter; only the low MAX_LEN_BITS of the length field are non-zero (legal 33..64).
- BLK_WORDS, 16, words per block; fixed at 16, any other value is a synthesis error.

Ports:
- clk  input  1  system clock, all state on rising edge.
- reset  input  1  asynchronous, active-high reset.
- in_valid  input  1  in_data/in_bytes/in_last valid.
- in_ready  output  1  padder can accept a word this cycle.
- in_data  input  32  message word; first stream byte in [31:24].
- in_bytes  input  3  valid bytes in word, 1..4; 0 legal only with in_last (empty tail word).
- in_last  input  1  final word of message.
- blk_valid  output  1  blk_data holds a complete block.
- blk_ready  input  1  core accepts block.
- blk_data  output  512  block; word 0 (first 4 bytes) in [31:0], word 15 in [511:480].
- blk_first  output  1  block is the first of its message.
- blk_last  output  1  block is the final (length-carrying) block.
- busy  output  1  high from first accepted word until the last block is accepted.

Behaviour:
- Reset: all outputs 0, buffer cleared, byte pointer 0, length counter 0, state ABSORB. Reset mid-message discards everything; no partial block is ever emitted.
- States:
  - ABSORB: in_ready=1. On in_valid&in_ready, write in_data at the byte pointer and advance it by in_bytes; bit length += 8*in_bytes.
  - Non-last words must have in_bytes=4; otherwise behaviour is undefined. With the optional feature compiled in, the word is flagged.
  - Pointer reaches 64 without in_last -> EMIT.
  - in_last -> PAD.
  - PAD (1 cycle): at the current pointer p, write 0x80 at byte p; clear bytes p+1..63.
    - p<=55: write the length big-endian into bytes 56..63 -> EMIT_FINAL.
    - p>=56: -> EMIT_SPILL.
  - EMIT / EMIT_SPILL / EMIT_FINAL: blk_valid=1, in_ready=0; blk_data, blk_first and blk_last are held stable until blk_ready.
    - On handshake from EMIT: clear buffer, pointer 0 -> ABSORB.
    - On handshake from EMIT_SPILL: load an all-zero block with the length in bytes 56..63 -> EMIT_FINAL.
    - On handshake from EMIT_FINAL: clear length, pointer and first-flag -> ABSORB.
  - in_last on a word that fills byte 63 (p=64 after the write): PAD places 0x80 in byte 0 of a fresh block. The full data block is emitted first through EMIT, then the pad block. Implement this as a pending-pad flag checked on return to ABSORB; it takes priority over new input.
- blk_first: set for the first block emitted after reset or after an EMIT_FINAL handshake.
- blk_last: set only in EMIT_FINAL. A one-block message has first=last=1.
- Latency:
  - 16th data word accepted -> blk_valid on the next cycle.
  - in_last accepted -> blk_valid 2 cycles later (PAD + register).
- Length counter is 64 bits wide; it wraps modulo 2^MAX_LEN_BITS with no error.
- in_valid while in_ready=0 is ignored; upstream must hold the word.
- blk_ready while blk_valid=0 is ignored.
- There is no combinational path from in_valid/blk_ready to in_ready/blk_valid.

Optional Feature:
- Macro: SHA1_PAD_PROTOCOL_CHECK_EN.
- Compiled in:
  - Adds output proto_err (1 bit), sticky until reset.
  - Sets on: in_bytes<4 without in_last; in_bytes=0 without in_last; in_bytes>4.
  - The offending word is still absorbed, counting min(in_bytes,4) bytes.
- Compiled out: port absent, no checking logic; these inputs are undefined behaviour.

Test Plan:
- Empty message: one word, in_bytes=0, in_last=1 -> one block; word0=0x80000000, words1..15=0; first=last=1.
- "abc": in_data=0x61626300, in_bytes=3, in_last -> word0=0x61626380, word15=0x00000018, words1..14=0; core digest must be a9993e36 4706816a ba3e2571 7850c26c 9cd0d89d.
- 55-byte message (13 full words + 3 bytes): single block, 0x80 at byte 55, word15=0x000001B8.
- 56-byte message: block1 has 0x80 at byte 56, rest zero, first=1 last=0; block2 all zero, word15=0x000001C0, first=0 last=1.
- 64-byte message: block1 is pure data; block2 word0=0x80000000, word15=0x00000200, last=1.
- Hold blk_ready=0 for 10 cycles during EMIT -> blk_data stable, in_ready=0, no words lost; then assert reset mid-message -> all outputs 0 next edge; a fresh "abc" afterwards gives blk_first=1 and the correct block.

Source files
------------

// File: rtl/sha1_msg_padder.sv
// SHA-1 message padder: packs 32-bit big-endian words into 512-bit blocks with FIPS 180-4 padding.
// Optional protocol checker and sticky proto_err output: define SHA1_PAD_PROTOCOL_CHECK_EN.
module sha1_msg_padder #(
  parameter int unsigned MAX_LEN_BITS = 64,
  parameter int unsigned BLK_WORDS    = 16
) (
  input  logic         clk,
  input  logic         reset,
  input  logic         in_valid,
  output logic         in_ready,
  input  logic [31:0]  in_data,
  input  logic [2:0]   in_bytes,
  input  logic         in_last,
  output logic         blk_valid,
  input  logic         blk_ready,
  output logic [511:0] blk_data,
  output logic         blk_first,
  output logic         blk_last,
  output logic         busy
`ifdef SHA1_PAD_PROTOCOL_CHECK_EN
  ,
  output logic         proto_err
`endif
);

  localparam int unsigned BLK_BYTES = BLK_WORDS * 4;
  localparam logic [63:0] LEN_MASK  = {64{1'b1}} >> (64 - MAX_LEN_BITS);

  if (BLK_WORDS != 16) begin : g_bad_blk_words
    $error("sha1_msg_padder: BLK_WORDS must be 16");
  end
  if (MAX_LEN_BITS < 33 || MAX_LEN_BITS > 64) begin : g_bad_len_bits
    $error("sha1_msg_padder: MAX_LEN_BITS must be 33..64");
  end

  localparam logic [2:0] S_ABSORB = 3'd0;
  localparam logic [2:0] S_PAD    = 3'd1;
  localparam logic [2:0] S_EMIT   = 3'd2;
  localparam logic [2:0] S_SPILL  = 3'd3;
  localparam logic [2:0] S_FINAL  = 3'd4;

  logic [2:0]   state, state_n;
  logic [511:0] buf_q, buf_n;
  logic [6:0]   ptr_q, ptr_n;
  logic [63:0]  len_q, len_n;
  logic         pend_q, pend_n;
  logic         sent_q, sent_n;
  logic         busy_n;
  logic         in_ready_n, blk_valid_n, blk_first_n, blk_last_n;
  logic [2:0]   nb;
  logic [5:0]   pad_p;
  logic         acc;

  // Bit offset of stream byte b: word b/4, big-endian within the word.
  function automatic logic [8:0] byte_lsb(input logic [5:0] b);
    return {b[5:2], 5'b0} + {4'b0, ~b[1:0], 3'b0};
  endfunction

  assign nb    = (in_bytes > 3'd4) ? 3'd4 : in_bytes;
  assign acc   = in_valid && in_ready;
  assign pad_p = ptr_q[5:0];

  // Next-state, datapath and registered-output decode.
  always_comb begin
    state_n = state;
    buf_n   = buf_q;
    ptr_n   = ptr_q;
    len_n   = len_q;
    pend_n  = pend_q;
    sent_n  = sent_q;
    busy_n  = busy;
    case (state)
      S_ABSORB: begin
        if (pend_q) begin
          state_n = S_PAD;
        end else if (acc) begin
          for (int k = 0; k < 4; k++) begin
            if (3'(k) < nb && (ptr_q + 7'(k)) < 7'(BLK_BYTES)) begin
              buf_n[byte_lsb(6'(ptr_q + 7'(k))) +: 8] = in_data[31-8*k -: 8];
            end
          end
          ptr_n  = ptr_q + 7'(nb);
          len_n  = (len_q + (64'(nb) << 3)) & LEN_MASK;
          busy_n = 1'b1;
          if (ptr_n >= 7'(BLK_BYTES)) begin
            state_n = S_EMIT;
            pend_n  = in_last;
          end else if (in_last) begin
            state_n = S_PAD;
          end
        end
      end
      S_PAD: begin
        for (int j = 0; j < 64; j++) begin
          if (6'(j) > pad_p) buf_n[byte_lsb(6'(j)) +: 8] = 8'h00;
        end
        buf_n[byte_lsb(pad_p) +: 8] = 8'h80;
        pend_n = 1'b0;
        if (ptr_q <= 7'd55) begin
          buf_n[511:448] = {len_q[31:0], len_q[63:32]};
          state_n = S_FINAL;
        end else begin
          state_n = S_SPILL;
        end
      end
      S_EMIT: begin
        if (blk_ready) begin
          buf_n   = '0;
          ptr_n   = '0;
          sent_n  = 1'b1;
          state_n = S_ABSORB;
        end
      end
      S_SPILL: begin
        if (blk_ready) begin
          buf_n          = '0;
          buf_n[511:448] = {len_q[31:0], len_q[63:32]};
          sent_n         = 1'b1;
          state_n        = S_FINAL;
        end
      end
      S_FINAL: begin
        if (blk_ready) begin
          buf_n   = '0;
          ptr_n   = '0;
          len_n   = '0;
          sent_n  = 1'b0;
          busy_n  = 1'b0;
          state_n = S_ABSORB;
        end
      end
      default: state_n = S_ABSORB;
    endcase
    in_ready_n  = (state_n == S_ABSORB) && !pend_n;
    blk_valid_n = (state_n == S_EMIT) || (state_n == S_SPILL) || (state_n == S_FINAL);
    blk_first_n = blk_valid_n && !sent_n;
    blk_last_n  = (state_n == S_FINAL);
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state     <= S_ABSORB;
      buf_q     <= '0;
      ptr_q     <= '0;
      len_q     <= '0;
      pend_q    <= 1'b0;
      sent_q    <= 1'b0;
      busy      <= 1'b0;
      in_ready  <= 1'b0;
      blk_valid <= 1'b0;
      blk_first <= 1'b0;
      blk_last  <= 1'b0;
    end else begin
      state     <= state_n;
      buf_q     <= buf_n;
      ptr_q     <= ptr_n;
      len_q     <= len_n;
      pend_q    <= pend_n;
      sent_q    <= sent_n;
      busy      <= busy_n;
      in_ready  <= in_ready_n;
      blk_valid <= blk_valid_n;
      blk_first <= blk_first_n;
      blk_last  <= blk_last_n;
    end
  end

  assign blk_data = buf_q;

`ifdef SHA1_PAD_PROTOCOL_CHECK_EN
  // Sticky flag for short or oversized non-final words and oversized tails.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      proto_err <= 1'b0;
    end else if (acc && !pend_q && ((in_bytes != 3'd4 && !in_last) || in_bytes > 3'd4)) begin
      proto_err <= 1'b1;
    end
  end
`endif

endmodule

// File: tb/tb_sha1_msg_padder.sv
// Directed self-checking bench for sha1_msg_padder.
module tb_sha1_msg_padder;

  logic         clk = 1'b0;
  logic         reset;
  logic         in_valid;
  logic         in_ready;
  logic [31:0]  in_data;
  logic [2:0]   in_bytes;
  logic         in_last;
  logic         blk_valid;
  logic         blk_ready;
  logic [511:0] blk_data;
  logic         blk_first;
  logic         blk_last;
  logic         busy;
`ifdef SHA1_PAD_PROTOCOL_CHECK_EN
  logic         proto_err;
`endif

  int checks = 0;
  int errors = 0;

  always #5 clk = ~clk;

  sha1_msg_padder dut (
    .clk       (clk),
    .reset     (reset),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .in_data   (in_data),
    .in_bytes  (in_bytes),
    .in_last   (in_last),
    .blk_valid (blk_valid),
    .blk_ready (blk_ready),
    .blk_data  (blk_data),
    .blk_first (blk_first),
    .blk_last  (blk_last),
    .busy      (busy)
`ifdef SHA1_PAD_PROTOCOL_CHECK_EN
    ,
    .proto_err (proto_err)
`endif
  );

  task automatic check(input string tag, input logic [511:0] got, input logic [511:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  // Message byte i has value i.
  function automatic logic [31:0] mkword(input int w);
    return {8'(4*w), 8'(4*w+1), 8'(4*w+2), 8'(4*w+3)};
  endfunction

  function automatic logic [511:0] data_blk(input int nwords);
    logic [511:0] b = '0;
    for (int w = 0; w < nwords; w++) b[32*w +: 32] = mkword(w);
    return b;
  endfunction

  task automatic send_word(input logic [31:0] d, input logic [2:0] nbytes, input logic last);
    int n = 0;
    @(negedge clk);
    in_valid = 1'b1;
    in_data  = d;
    in_bytes = nbytes;
    in_last  = last;
    while (!in_ready && n < 200) begin
      @(negedge clk);
      n++;
    end
    if (!in_ready) check("in_ready_timeout", in_ready, 1);
    @(posedge clk);
    #1 in_valid = 1'b0;
  endtask

  task automatic get_block(input string tag, input logic [511:0] exp, input logic f, input logic l);
    int n = 0;
    @(negedge clk);
    while (!blk_valid && n < 200) begin
      @(negedge clk);
      n++;
    end
    check({tag, "_valid"}, blk_valid, 1);
    check({tag, "_data"},  blk_data,  exp);
    check({tag, "_first"}, blk_first, f);
    check({tag, "_last"},  blk_last,  l);
    blk_ready = 1'b1;
    @(posedge clk);
    #1 blk_ready = 1'b0;
  endtask

  task automatic check_idle_outputs(input string tag);
    check({tag, "_in_ready"},  in_ready,  0);
    check({tag, "_blk_valid"}, blk_valid, 0);
    check({tag, "_blk_data"},  blk_data,  0);
    check({tag, "_blk_first"}, blk_first, 0);
    check({tag, "_blk_last"},  blk_last,  0);
    check({tag, "_busy"},      busy,      0);
  endtask

  logic [511:0] exp;

  initial begin
    reset     = 1'b1;
    in_valid  = 1'b0;
    in_data   = '0;
    in_bytes  = '0;
    in_last   = 1'b0;
    blk_ready = 1'b0;
    repeat (3) @(negedge clk);
    check_idle_outputs("reset");
    reset = 1'b0;

    // Empty message
    send_word(32'h0, 3'd0, 1'b1);
    exp = '0;
    exp[31:0] = 32'h80000000;
    get_block("empty", exp, 1'b1, 1'b1);
    @(negedge clk);
    check("empty_busy_after", busy, 0);

    // "abc" with latency check: PAD cycle, then blk_valid
    send_word(32'h61626300, 3'd3, 1'b1);
    @(negedge clk);
    check("abc_lat_pad", blk_valid, 0);
    check("abc_busy", busy, 1);
    @(negedge clk);
    check("abc_lat_valid", blk_valid, 1);
    exp = '0;
    exp[31:0]    = 32'h61626380;
    exp[511:480] = 32'h00000018;
    get_block("abc", exp, 1'b1, 1'b1);

    // 55 bytes: last word carries 3 bytes, its 4th byte must be ignored
    for (int i = 0; i < 13; i++) send_word(mkword(i), 3'd4, 1'b0);
    send_word(32'h34353637, 3'd3, 1'b1);
    exp = data_blk(13);
    exp[13*32 +: 32] = 32'h34353680;
    exp[511:480]     = 32'h000001B8;
    get_block("len55", exp, 1'b1, 1'b1);

    // 56 bytes: spill into a length-only block
    for (int i = 0; i < 14; i++) send_word(mkword(i), 3'd4, (i == 13));
    exp = data_blk(14);
    exp[14*32 +: 32] = 32'h80000000;
    get_block("len56_b1", exp, 1'b1, 1'b0);
    exp = '0;
    exp[511:480] = 32'h000001C0;
    get_block("len56_b2", exp, 1'b0, 1'b1);

    // 64 bytes: pending pad after a pure data block
    for (int i = 0; i < 16; i++) send_word(mkword(i), 3'd4, (i == 15));
    @(negedge clk);
    check("len64_lat", blk_valid, 1);
    get_block("len64_b1", data_blk(16), 1'b1, 1'b0);
    exp = '0;
    exp[31:0]    = 32'h80000000;
    exp[511:480] = 32'h00000200;
    get_block("len64_b2", exp, 1'b0, 1'b1);

    // 68 bytes with a 10-cycle stall while the next word waits upstream
    for (int i = 0; i < 16; i++) send_word(mkword(i), 3'd4, 1'b0);
    in_valid = 1'b1;
    in_data  = mkword(16);
    in_bytes = 3'd4;
    in_last  = 1'b1;
    for (int c = 0; c < 10; c++) begin
      @(negedge clk);
      if (c == 0 || c == 9) begin
        check("stall_valid",    blk_valid, 1);
        check("stall_data",     blk_data,  data_blk(16));
        check("stall_in_ready", in_ready,  0);
      end
    end
    get_block("len68_b1", data_blk(16), 1'b1, 1'b0);
    send_word(mkword(16), 3'd4, 1'b1);
    exp = '0;
    exp[31:0]    = 32'h40414243;
    exp[63:32]   = 32'h80000000;
    exp[511:480] = 32'h00000220;
    get_block("len68_b2", exp, 1'b0, 1'b1);

    // Reset mid-message discards partial data
    for (int i = 0; i < 3; i++) send_word(mkword(i), 3'd4, 1'b0);
    @(negedge clk);
    check("mid_busy", busy, 1);
    reset = 1'b1;
    @(posedge clk);
    #1 check_idle_outputs("mid_reset");
    @(negedge clk);
    reset = 1'b0;
    send_word(32'h61626300, 3'd3, 1'b1);
    exp = '0;
    exp[31:0]    = 32'h61626380;
    exp[511:480] = 32'h00000018;
    get_block("abc_after_reset", exp, 1'b1, 1'b1);
    @(negedge clk);
    check("final_busy", busy, 0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
